ram_banked: RTL and testbench
=============================

RAM_BANKED -- requirements
Module: ram_banked

Interface -- parameters
REQ-001 SHALL have parameter WSIZE, default 4, word width in bytes; data width is WSIZE*8.
REQ-002 SHALL have parameter NBANKS, default 2, bank count; legal values are powers of two, 1..16.
REQ-003 SHALL have parameter BANK_AW, default 7, address bits per bank; depth is NBANKS*2^BANK_AW words.
REQ-004 SHALL have parameter INIT_ZERO, default 1; when 1, memory is cleared after reset; when 0, no clear is performed.

Interface -- ports
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named CLK and RESETn.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port RESETn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port EN0, input, 1 bit: request valid.
REQ-009 SHALL have port RDY0, output, 1 bit: request ready; a request is accepted in a cycle where EN0 and RDY0 are both 1.
REQ-010 SHALL have port WE0, input, WSIZE bits: per-byte write enable; all zero means read.
REQ-011 SHALL have port A0, input, AW bits (AW = log2(NBANKS)+BANK_AW): word address.
REQ-012 SHALL have port Di0, input, WSIZE*8 bits: write data.
REQ-013 SHALL have port Do0, output, WSIZE*8 bits: registered read data.
REQ-014 SHALL have port DV0, output, 1 bit: read-data-valid pulse.

Function
REQ-015 Bank index SHALL be the upper log2(NBANKS) bits of A0; row SHALL be A0[BANK_AW-1:0]; with NBANKS=1 the bank index is absent.
REQ-016 Storage SHALL be flip-flop based, with one array per bank; only the selected bank is enabled per accepted request.
REQ-017 FSM SHALL have states INIT and IDLE; reset enters INIT if INIT_ZERO=1, else IDLE.
REQ-018 In INIT, a clear counter SHALL walk 0..depth-1 one word per cycle, writing zero; it then moves to IDLE on the cycle after the last word is written.
REQ-019 RDY0 SHALL be 0 in INIT and 1 in IDLE; requests presented during INIT SHALL be ignored, with no side effects.
REQ-020 An accepted write SHALL update only the bytes whose WE0 bit is 1, visible to any request accepted in the following cycle or later.
REQ-021 An accepted read SHALL drive Do0 with the addressed word and DV0=1 exactly one cycle after acceptance (latency 1).
REQ-022 The output mux select SHALL come from the bank index registered at acceptance, never from the live A0.
REQ-023 Do0 SHALL hold its last read value until the next read completes; writes SHALL NOT change Do0 or assert DV0.
REQ-024 DV0 SHALL be 0 in every cycle not covered by REQ-021.
REQ-025 Back-to-back reads SHALL be supported at one per cycle, with DV0 held high continuously.
REQ-026 A read accepted the cycle after a write to the same address SHALL return the newly written bytes merged with the old unwritten bytes.
REQ-027 Address arithmetic SHALL be unsigned; every address in 0..depth-1 is valid, with no wrap or error.

Reset
REQ-028 On RESETn=0, regardless of clock: Do0=0, DV0=0, RDY0=0, clear counter=0, FSM=INIT (or IDLE if INIT_ZERO=0, with RDY0=1 only after RESETn deasserts).
REQ-029 Reset asserted mid-INIT or mid-read SHALL abort the operation; the DV0 pending from the aborted read SHALL NOT assert, and INIT restarts from word 0.
REQ-030 Memory contents SHALL NOT be reset directly; with INIT_ZERO=0 they are undefined after power-up and retained across reset.

Verification
REQ-031 Defaults, release reset -> RDY0=0 for 256 cycles, then 1; reads of addresses 0, 127, 128 and 255 return 0 with DV0 one cycle later.
REQ-032 Write 0xA5A5A5A5 @0x80 with WE0=0xF; next cycle write 0x12345678 @0x80 with WE0=0x3; then read 0x80 -> Do0=0xA5A55678; read 0x00 -> 0.
REQ-033 Reads @0x05, 0x85, 0x05 in consecutive cycles (after writing 0x11 and 0x22) -> DV0 high 3 cycles, Do0 = 0x11, 0x22, 0x11, showing the registered bank select.
REQ-034 Assert RESETn=0 at clear counter=100, release -> INIT restarts, RDY0 low 256 more cycles; a read in flight at reset gives no DV0.
REQ-035 NBANKS=4, BANK_AW=4, WSIZE=2, INIT_ZERO=0: write i+1 to every address 0..63, read all -> each returns i+1; EN0 during reset -> no write.

Source files
------------

// File: rtl/ram_banked_if.sv
// Request/response bus for ram_banked: one request port with per-byte write
// enables, a ready/valid acceptance handshake and a registered read return.
interface ram_banked_if #(
    parameter int WSIZE   = 4,
    parameter int NBANKS  = 2,
    parameter int BANK_AW = 7
);
    localparam int AW = $clog2(NBANKS) + BANK_AW;

    logic               EN0;
    logic               RDY0;
    logic [WSIZE-1:0]   WE0;
    logic [AW-1:0]      A0;
    logic [WSIZE*8-1:0] Di0;
    logic [WSIZE*8-1:0] Do0;
    logic               DV0;

    modport master (
        output EN0, WE0, A0, Di0,
        input  RDY0, Do0, DV0
    );

    modport slave (
        input  EN0, WE0, A0, Di0,
        output RDY0, Do0, DV0
    );
endinterface

// File: rtl/ram_banked.sv
// Banked flip-flop RAM with byte write enables, single-cycle read latency and
// an optional post-reset clear walk that zeroes every word before accepting requests.
module ram_banked #(
    parameter int WSIZE     = 4,
    parameter int NBANKS    = 2,
    parameter int BANK_AW   = 7,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        RESETn,
    ram_banked_if.slave bus
);
    localparam int DW    = WSIZE * 8;
    localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int AW    = $clog2(NBANKS) + BANK_AW;
    localparam int ROWS  = 1 << BANK_AW;
    localparam int DEPTH = NBANKS * ROWS;
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    typedef enum logic {INIT, IDLE} state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      clrCnt_q, clrCnt_d;
    logic               rdy_q;
    logic               dv_q;
    logic [BW-1:0]      bankSel_q;
    logic [DW-1:0]      rdata_q [NBANKS];
    logic [DW-1:0]      mem_q   [NBANKS][ROWS];

    logic               accept;
    logic               isRead;
    logic               isWrite;
    logic [BW-1:0]      reqBank;
    logic [BW-1:0]      clrBank;
    logic [BANK_AW-1:0] reqRow;
    logic [BANK_AW-1:0] clrRow;
    logic               wrEn;
    logic [BW-1:0]      wrBank;
    logic [BANK_AW-1:0] wrRow;
    logic [WSIZE-1:0]   wrBe;
    logic [DW-1:0]      wrData;

    assign accept   = bus.EN0 & rdy_q;
    assign isRead   = accept & ~(|bus.WE0);
    assign isWrite  = accept & (|bus.WE0);
    assign reqRow   = bus.A0[BANK_AW-1:0];
    assign clrRow   = clrCnt_q[BANK_AW-1:0];
    assign bus.RDY0 = rdy_q;
    assign bus.DV0  = dv_q;

    // Output mux is steered by the bank captured at acceptance, not the live address.
    generate
        if (NBANKS > 1) begin : gBankIdx
            assign reqBank = bus.A0[AW-1:BANK_AW];
            assign clrBank = clrCnt_q[AW-1:BANK_AW];
            assign bus.Do0 = rdata_q[bankSel_q];
        end else begin : gSingleBank
            assign reqBank = '0;
            assign clrBank = '0;
            assign bus.Do0 = rdata_q[0];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        case (state_q)
            INIT: begin
                clrCnt_d = clrCnt_q + AW'(1);
                if (clrCnt_q == LAST_WORD) begin
                    state_d  = IDLE;
                    clrCnt_d = '0;
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The clear walk and host writes share one write port; the clear owns it in INIT.
    always_comb begin
        wrEn   = 1'b0;
        wrBank = reqBank;
        wrRow  = reqRow;
        wrBe   = bus.WE0;
        wrData = bus.Di0;
        if (state_q == INIT) begin
            wrEn   = RESETn;
            wrBank = clrBank;
            wrRow  = clrRow;
            wrBe   = '1;
            wrData = '0;
        end else if (isWrite) begin
            wrEn = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            if (INIT_ZERO) begin
                state_q <= INIT;
            end else begin
                state_q <= IDLE;
            end
            clrCnt_q  <= '0;
            rdy_q     <= 1'b0;
            dv_q      <= 1'b0;
            bankSel_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
            rdy_q    <= (state_d == IDLE);
            dv_q     <= isRead;
            if (isRead) begin
                bankSel_q <= reqBank;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int b = 0; b < NBANKS; b++) begin
                rdata_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                if (isRead && (reqBank == BW'(b))) begin
                    rdata_q[b] <= mem_q[b][reqRow];
                end
            end
        end
    end

    // Storage is deliberately not reset so contents survive a reset when no clear is requested.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < NBANKS; b++) begin
            for (int k = 0; k < WSIZE; k++) begin
                if (wrEn && (wrBank == BW'(b)) && wrBe[k]) begin
                    mem_q[b][wrRow][k*8 +: 8] <= wrData[k*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_banked.sv
// Self-checking bench for ram_banked: a default-configured instance with the
// clear walk, and a 4-bank 16-bit instance without it, both against a word-array model.
module tb_ram_banked;
    logic CLK;
    logic resetnA;
    logic resetnB;

    ram_banked_if #(.WSIZE(4), .NBANKS(2), .BANK_AW(7)) busA ();
    ram_banked_if #(.WSIZE(2), .NBANKS(4), .BANK_AW(4)) busB ();

    ram_banked #(.WSIZE(4), .NBANKS(2), .BANK_AW(7), .INIT_ZERO(1'b1)) dutA (
        .CLK    (CLK),
        .RESETn (resetnA),
        .bus    (busA.slave)
    );

    ram_banked #(.WSIZE(2), .NBANKS(4), .BANK_AW(4), .INIT_ZERO(1'b0)) dutB (
        .CLK    (CLK),
        .RESETn (resetnB),
        .bus    (busB.slave)
    );

    typedef struct {
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        expDv;
        logic [31:0] expDo;
    } vec_t;

    int          checkCount = 0;
    int          passCount  = 0;
    logic        actDv;
    logic [31:0] actDo;
    logic        expDv;
    logic [31:0] refMem [2][256];
    logic [31:0] lastDo [2];
    vec_t        vecs   [12];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One request cycle: drive between edges, sample #1 after the accepting edge, update the model.
    task automatic applyStimulus(input int dut, input logic en, input logic [3:0] we,
                                 input logic [7:0] addr, input logic [31:0] data);
        logic [3:0] weEff;
        logic [7:0] addrEff;
        int         nb;
        nb      = (dut == 0) ? 4 : 2;
        weEff   = (dut == 0) ? we : (we & 4'h3);
        addrEff = (dut == 0) ? addr : (addr & 8'h3F);
        @(negedge CLK);
        if (dut == 0) begin
            busA.EN0 = en;
            busA.WE0 = we;
            busA.A0  = addr;
            busA.Di0 = data;
        end else begin
            busB.EN0 = en;
            busB.WE0 = we[1:0];
            busB.A0  = addr[5:0];
            busB.Di0 = data[15:0];
        end
        @(posedge CLK);
        #1;
        if (dut == 0) begin
            actDv    = busA.DV0;
            actDo    = busA.Do0;
            busA.EN0 = 1'b0;
        end else begin
            actDv    = busB.DV0;
            actDo    = {16'h0, busB.Do0};
            busB.EN0 = 1'b0;
        end
        expDv = 1'b0;
        if (en) begin
            if (weEff == 4'h0) begin
                expDv       = 1'b1;
                lastDo[dut] = refMem[dut][addrEff];
            end else begin
                for (int k = 0; k < nb; k++) begin
                    if (weEff[k]) refMem[dut][addrEff][k*8 +: 8] = data[k*8 +: 8];
                end
            end
        end
    endtask

    task automatic checkCycle(input int dut, input string name);
        checkOutput($sformatf("%s.dv", name), {31'b0, actDv}, {31'b0, expDv});
        checkOutput($sformatf("%s.do", name), actDo, lastDo[dut]);
    endtask

    // Counts edges after reset release until RDY0 rises on instance A, with requests held on the bus.
    task automatic waitInitA(output int edges, output int dvSeen);
        edges  = 0;
        dvSeen = 0;
        while (edges < 400) begin
            busA.EN0 = 1'b1;
            busA.WE0 = (edges < 100) ? 4'h0 : 4'hF;
            busA.A0  = 8'h05;
            busA.Di0 = 32'hDEADBEEF;
            @(posedge CLK);
            #1;
            edges++;
            if (busA.DV0) dvSeen++;
            if (busA.RDY0) break;
        end
        busA.EN0 = 1'b0;
    endtask

    initial begin
        int edges;
        int dvSeen;
        logic [3:0] rWe;
        logic [7:0] rAddr;

        vecs[0]  = '{4'hF, 8'h80, 32'hA5A5A5A5, 1'b0, 32'h00000000};
        vecs[1]  = '{4'h3, 8'h80, 32'h12345678, 1'b0, 32'h00000000};
        vecs[2]  = '{4'h0, 8'h80, 32'h00000000, 1'b1, 32'hA5A55678};
        vecs[3]  = '{4'h0, 8'h00, 32'h00000000, 1'b1, 32'h00000000};
        vecs[4]  = '{4'hF, 8'h05, 32'h00000011, 1'b0, 32'h00000000};
        vecs[5]  = '{4'hF, 8'h85, 32'h00000022, 1'b0, 32'h00000000};
        vecs[6]  = '{4'h0, 8'h05, 32'h00000000, 1'b1, 32'h00000011};
        vecs[7]  = '{4'h0, 8'h85, 32'h00000000, 1'b1, 32'h00000022};
        vecs[8]  = '{4'h0, 8'h05, 32'h00000000, 1'b1, 32'h00000011};
        vecs[9]  = '{4'h0, 8'h80, 32'h00000000, 1'b1, 32'hA5A55678};
        vecs[10] = '{4'h1, 8'h80, 32'h000000FF, 1'b0, 32'hA5A55678};
        vecs[11] = '{4'h0, 8'h80, 32'h00000000, 1'b1, 32'hA5A556FF};

        for (int d = 0; d < 2; d++) begin
            lastDo[d] = '0;
            for (int a = 0; a < 256; a++) refMem[d][a] = '0;
        end
        resetnA  = 1'b0;
        resetnB  = 1'b0;
        busA.EN0 = 1'b0; busA.WE0 = '0; busA.A0 = '0; busA.Di0 = '0;
        busB.EN0 = 1'b0; busB.WE0 = '0; busB.A0 = '0; busB.Di0 = '0;

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("resetA.rdy", {31'b0, busA.RDY0}, 32'd0);
        checkOutput("resetA.dv",  {31'b0, busA.DV0},  32'd0);
        checkOutput("resetA.do",  busA.Do0,           32'd0);

        @(negedge CLK);
        resetnA = 1'b1;
        #1;
        checkOutput("releaseA.rdy", {31'b0, busA.RDY0}, 32'd0);
        waitInitA(edges, dvSeen);
        checkOutput("initA.edges", edges, 32'd256);
        checkOutput("initA.dvDuringInit", dvSeen, 32'd0);

        applyStimulus(0, 1'b1, 4'h0, 8'h00, 32'h0); checkCycle(0, "rd0");
        applyStimulus(0, 1'b1, 4'h0, 8'd127, 32'h0); checkCycle(0, "rd127");
        applyStimulus(0, 1'b1, 4'h0, 8'd128, 32'h0); checkCycle(0, "rd128");
        applyStimulus(0, 1'b1, 4'h0, 8'd255, 32'h0); checkCycle(0, "rd255");
        applyStimulus(0, 1'b1, 4'h0, 8'h05, 32'h0); checkCycle(0, "rdIgnoredInitWrite");

        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].data);
            checkOutput($sformatf("vec%0d.dv", i), {31'b0, actDv}, {31'b0, vecs[i].expDv});
            checkOutput($sformatf("vec%0d.do", i), actDo, vecs[i].expDo);
        end
        applyStimulus(0, 1'b0, 4'h0, 8'h00, 32'h0); checkCycle(0, "idleHold");

        for (int i = 0; i < 300; i++) begin
            rWe   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rAddr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3) * 85) : 8'($urandom_range(0, 255));
            applyStimulus(0, ($urandom_range(0, 7) != 0), rWe, rAddr, $urandom);
            checkCycle(0, $sformatf("randA%0d", i));
        end

        // Reset with a read on the bus: the read must not be accepted and no DV0 may follow.
        @(negedge CLK);
        busA.EN0 = 1'b1; busA.WE0 = 4'h0; busA.A0 = 8'h80;
        #2 resetnA = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("abortRead.dv",  {31'b0, busA.DV0},  32'd0);
        checkOutput("abortRead.do",  busA.Do0,           32'd0);
        checkOutput("abortRead.rdy", {31'b0, busA.RDY0}, 32'd0);
        busA.EN0  = 1'b0;
        lastDo[0] = '0;
        @(negedge CLK);
        resetnA = 1'b1;
        repeat (100) @(posedge CLK);
        #1;
        resetnA = 1'b0;
        #2;
        checkOutput("midInitReset.rdy", {31'b0, busA.RDY0}, 32'd0);
        @(negedge CLK);
        resetnA = 1'b1;
        waitInitA(edges, dvSeen);
        checkOutput("reinitA.edges", edges, 32'd256);
        for (int a = 0; a < 256; a++) refMem[0][a] = '0;
        applyStimulus(0, 1'b1, 4'h0, 8'h80, 32'h0); checkCycle(0, "reinitRd80");
        applyStimulus(0, 1'b1, 4'h0, 8'd200, 32'h0); checkCycle(0, "reinitRd200");
        applyStimulus(0, 1'b1, 4'h0, 8'd255, 32'h0); checkCycle(0, "reinitRd255");

        checkOutput("resetB.rdy", {31'b0, busB.RDY0}, 32'd0);
        checkOutput("resetB.dv",  {31'b0, busB.DV0},  32'd0);
        checkOutput("resetB.do",  {16'h0, busB.Do0},  32'd0);
        @(negedge CLK);
        resetnB = 1'b1;
        #1;
        checkOutput("releaseB.rdyLow", {31'b0, busB.RDY0}, 32'd0);
        @(posedge CLK);
        #1;
        checkOutput("releaseB.rdyHigh", {31'b0, busB.RDY0}, 32'd1);

        for (int i = 0; i < 64; i++) begin
            applyStimulus(1, 1'b1, 4'h3, 8'(i), 32'(i + 1));
            checkCycle(1, $sformatf("wrB%0d", i));
        end
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1, 1'b1, 4'h0, 8'(i), 32'h0);
            checkOutput($sformatf("rdB%0d.dv", i), {31'b0, actDv}, 32'd1);
            checkOutput($sformatf("rdB%0d.do", i), actDo, 32'(i + 1));
        end

        // Writes presented while held in reset must leave memory untouched.
        @(negedge CLK);
        resetnB  = 1'b0;
        busB.EN0 = 1'b1; busB.WE0 = 2'h3; busB.A0 = 6'd3; busB.Di0 = 16'hBEEF;
        repeat (3) @(posedge CLK);
        #1;
        busB.A0 = 6'd40;
        @(posedge CLK);
        #1;
        checkOutput("resetB2.rdy", {31'b0, busB.RDY0}, 32'd0);
        busB.EN0 = 1'b0;
        @(negedge CLK);
        resetnB   = 1'b1;
        lastDo[1] = '0;
        @(posedge CLK);
        applyStimulus(1, 1'b1, 4'h0, 8'd3, 32'h0);
        checkOutput("retainB3", actDo, 32'd4);
        applyStimulus(1, 1'b1, 4'h0, 8'd40, 32'h0);
        checkOutput("retainB40", actDo, 32'd41);

        for (int i = 0; i < 150; i++) begin
            rWe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 3));
            applyStimulus(1, ($urandom_range(0, 5) != 0), rWe, 8'($urandom_range(0, 63)), $urandom);
            checkCycle(1, $sformatf("randB%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
